// File: rtl/lc3_mmio_bus_if.sv
// Datapath-side LC3 memory bus: MAR/MDR request held until a one-cycle completion strobe.
interface lc3_mmio_bus_if;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rd;
    logic        we;
    logic [15:0] rdata;
    logic        ready;

    modport master (output addr, wdata, rd, we, input rdata, ready);
    modport slave  (input addr, wdata, rd, we, output rdata, ready);
endinterface

// File: rtl/lc3_mmio_bus.sv
// LC3 memory-bus front end: routes datapath accesses to external memory or the KBD/DSP/MCR devices.
// Optional macro LC3_KBD_IRQ_EN adds the KBSR interrupt-enable bit and the kbd_irq_o output.
module lc3_mmio_bus #(
    parameter int unsigned KBD_DEPTH = 4,
    parameter logic [15:0] IO_BASE   = 16'hFE00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lc3_mmio_bus_if.slave        bus,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [15:0]          mem_addr_o,
    output logic [15:0]          mem_wdata_o,
    input  logic [15:0]          mem_rdata_i,
    input  logic                 mem_ready_i,
    input  logic [7:0]           kbd_data_i,
    input  logic                 kbd_valid_i,
    output logic                 kbd_ready_o,
    output logic [7:0]           disp_data_o,
    output logic                 disp_valid_o,
    input  logic                 disp_ready_i,
    output logic                 run_o
`ifdef LC3_KBD_IRQ_EN
    ,
    output logic                 kbd_irq_o
`endif
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned PTR_W  = $clog2(KBD_DEPTH);
    localparam int unsigned CNT_W  = $clog2(KBD_DEPTH + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(KBD_DEPTH);
    localparam logic [DATA_W-1:0] KBSR_ADDR = IO_BASE;
    localparam logic [DATA_W-1:0] KBDR_ADDR = IO_BASE + 16'd2;
    localparam logic [DATA_W-1:0] DSR_ADDR  = IO_BASE + 16'd4;
    localparam logic [DATA_W-1:0] DDR_ADDR  = IO_BASE + 16'd6;
    localparam logic [DATA_W-1:0] MCR_ADDR  = 16'hFFFE;
    localparam logic [DATA_W-1:0] MCR_RESET = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   bus_rdata_q, bus_rdata_d;
    logic                bus_ready_q, bus_ready_d;
    logic [DATA_W-1:0]   mcr_q, mcr_d;

    logic [CHAR_W-1:0]   fifo_q [KBD_DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                kbd_ready_q, kbd_ready_d;

    logic                disp_valid_q, disp_valid_d;
    logic [CHAR_W-1:0]   disp_data_q, disp_data_d;

    logic                fifo_empty_c;
    logic                push_c;
    logic                pop_c;
    logic                ddr_wr_c;
    logic                kbsr_ie_c;
    logic [DATA_W-1:0]   dev_rdata_c;

`ifdef LC3_KBD_IRQ_EN
    logic                ie_q, ie_d;
    logic                irq_q;
    assign kbsr_ie_c = ie_q;
    assign kbd_irq_o = irq_q;
`else
    assign kbsr_ie_c = 1'b0;
`endif

    assign fifo_empty_c = (count_q == '0);
    assign push_c       = kbd_valid_i & kbd_ready_q;

    assign bus.rdata    = bus_rdata_q;
    assign bus.ready    = bus_ready_q;
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign kbd_ready_o  = kbd_ready_q;
    assign disp_data_o  = disp_data_q;
    assign disp_valid_o = disp_valid_q;
    assign run_o        = mcr_q[15];

    // Device register read mux, evaluated against pre-edge state
    always_comb begin
        dev_rdata_c = '0;
        case (bus.addr)
            KBSR_ADDR: dev_rdata_c = {~fifo_empty_c, kbsr_ie_c, 14'b0};
            KBDR_ADDR: dev_rdata_c = fifo_empty_c ? '0 : {8'h00, fifo_q[head_q]};
            DSR_ADDR:  dev_rdata_c = {~disp_valid_q, 15'b0};
            DDR_ADDR:  dev_rdata_c = {8'h00, disp_data_q};
            MCR_ADDR:  dev_rdata_c = mcr_q;
            default:   dev_rdata_c = '0;
        endcase
    end

    // Access FSM: device accesses complete in IDLE, memory accesses wait in MEM
    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        bus_rdata_d = bus_rdata_q;
        bus_ready_d = 1'b0;
        mcr_d       = mcr_q;
        pop_c       = 1'b0;
        ddr_wr_c    = 1'b0;
`ifdef LC3_KBD_IRQ_EN
        ie_d        = ie_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.rd | bus.we) begin
                    if (bus.addr < IO_BASE) begin
                        state_d     = MEM;
                        mem_en_d    = 1'b1;
                        mem_we_d    = bus.we;
                        mem_addr_d  = bus.addr;
                        mem_wdata_d = bus.wdata;
                        bus_rdata_d = '0;
                    end else begin
                        state_d     = DONE;
                        bus_ready_d = 1'b1;
                        if (bus.we) begin
                            bus_rdata_d = '0;
                            ddr_wr_c    = (bus.addr == DDR_ADDR);
                            if (bus.addr == MCR_ADDR) begin
                                mcr_d = bus.wdata;
                            end
`ifdef LC3_KBD_IRQ_EN
                            if (bus.addr == KBSR_ADDR) begin
                                ie_d = bus.wdata[14];
                            end
`endif
                        end else begin
                            bus_rdata_d = dev_rdata_c;
                            pop_c       = (bus.addr == KBDR_ADDR) & ~fifo_empty_c;
                        end
                    end
                end
            end
            MEM: begin
                if (mem_ready_i) begin
                    state_d     = DONE;
                    bus_ready_d = 1'b1;
                    mem_en_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    bus_rdata_d = mem_we_q ? '0 : mem_rdata_i;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Keyboard FIFO bookkeeping and display handshake
    always_comb begin
        head_d       = pop_c  ? PTR_W'(head_q + PTR_W'(1)) : head_q;
        tail_d       = push_c ? PTR_W'(tail_q + PTR_W'(1)) : tail_q;
        count_d      = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
            2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
            default: count_d = count_q;
        endcase
        kbd_ready_d  = (count_d != FULL_CNT);

        disp_valid_d = disp_valid_q;
        disp_data_d  = disp_data_q;
        if (disp_valid_q & disp_ready_i) begin
            disp_valid_d = 1'b0;
        end
        // A write decoded while a character is pending is dropped, even if it drains this edge
        if (ddr_wr_c & ~disp_valid_q) begin
            disp_valid_d = 1'b1;
            disp_data_d  = bus.wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            bus_rdata_q  <= '0;
            bus_ready_q  <= 1'b0;
            mcr_q        <= MCR_RESET;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            kbd_ready_q  <= 1'b1;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            bus_rdata_q  <= bus_rdata_d;
            bus_ready_q  <= bus_ready_d;
            mcr_q        <= mcr_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            kbd_ready_q  <= kbd_ready_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[tail_q] <= kbd_data_i;
        end
    end

`ifdef LC3_KBD_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= ie_q & ~fifo_empty_c;
        end
    end
`endif

endmodule

// File: tb/tb_lc3_mmio_bus.sv
// Randomized self-checking bench for lc3_mmio_bus against a queue-based device model.
module tb_lc3_mmio_bus;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_en, mem_we, mem_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  kbd_data, disp_data;
    logic        kbd_valid, kbd_ready, disp_valid, disp_ready, run;

    lc3_mmio_bus_if bus_if ();

    lc3_mmio_bus #(.KBD_DEPTH(DEPTH), .IO_BASE(16'hFE00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .mem_ready_i  (mem_ready),
        .kbd_data_i   (kbd_data),
        .kbd_valid_i  (kbd_valid),
        .kbd_ready_o  (kbd_ready),
        .disp_data_o  (disp_data),
        .disp_valid_o (disp_valid),
        .disp_ready_i (disp_ready),
        .run_o        (run)
    );

    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    bit          rand_io;

    // Reference model: FIFO contents, display latch and MCR
    logic [7:0]  m_kq [$];
    bit          m_dv;
    logic [7:0]  m_dd;
    logic [15:0] m_mcr;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %04h expected %04h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies one clock edge's worth of device semantics to the model
    task automatic edge_model(input bit dev, input bit we, input logic [15:0] a,
                              input logic [15:0] wd, output logic [15:0] rexp);
        bit push;
        bit dv_next;
        push    = kbd_valid && (m_kq.size() < DEPTH);
        dv_next = m_dv;
        rexp    = 16'h0000;
        if (m_dv && disp_ready) dv_next = 1'b0;
        if (dev) begin
            if (we) begin
                if (a == 16'hFE06 && !m_dv) begin
                    dv_next = 1'b1;
                    m_dd    = wd[7:0];
                end
                if (a == 16'hFFFE) m_mcr = wd;
            end else begin
                case (a)
                    16'hFE00: rexp = {(m_kq.size() != 0), 15'b0};
                    16'hFE02: if (m_kq.size() != 0) rexp = {8'h00, m_kq.pop_front()};
                    16'hFE04: rexp = {!m_dv, 15'b0};
                    16'hFE06: rexp = {8'h00, m_dd};
                    16'hFFFE: rexp = m_mcr;
                    default:  rexp = 16'h0000;
                endcase
            end
        end
        if (push) m_kq.push_back(kbd_data);
        m_dv = dv_next;
    endtask

    task automatic tick(input bit dev, input bit we, input logic [15:0] a,
                        input logic [15:0] wd, output logic [15:0] rexp);
        edge_model(dev, we, a, wd, rexp);
        @(posedge clk);
        @(negedge clk);
        check("kbd_ready", kbd_ready, (m_kq.size() < DEPTH));
        check("disp_valid", disp_valid, m_dv);
        check("disp_data", disp_data, m_dd);
        check("run", run, m_mcr[15]);
        if (rand_io) begin
            kbd_valid  = ($urandom_range(0, 99) < 40);
            kbd_data   = 8'($urandom);
            disp_ready = ($urandom_range(0, 99) < 30);
        end
    endtask

    task automatic idle(input int n);
        logic [15:0] r;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0, 16'h0, r);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus_if.rd  = 1'b0;
        bus_if.we  = 1'b0;
        kbd_valid  = 1'b0;
        disp_ready = 1'b0;
        mem_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_kq.delete();
        m_dv  = 1'b0;
        m_dd  = 8'h00;
        m_mcr = 16'h8000;
    endtask

    // One complete bus transaction; lat_i=0 picks a random memory latency
    task automatic do_access(input bit we, input logic [15:0] a, input logic [15:0] wd,
                             input int lat_i, input logic [15:0] md, output logic [15:0] got);
        logic [15:0] rexp;
        logic [15:0] exp_rd;
        int          lat;
        bus_if.addr  = a;
        bus_if.wdata = wd;
        bus_if.we    = we;
        bus_if.rd    = we ? ($urandom_range(0, 3) == 0) : 1'b1;
        if (a < 16'hFE00) begin
            tick(1'b0, 1'b0, 16'h0, 16'h0, rexp);
            check("mem_en_start", mem_en, 1'b1);
            check("mem_we", mem_we, we);
            check("mem_addr", mem_addr, a);
            if (we) check("mem_wdata", mem_wdata, wd);
            check("bus_ready_early", bus_if.ready, 1'b0);
            lat    = (lat_i > 0) ? lat_i : int'($urandom_range(1, 4));
            exp_rd = we ? 16'h0000 : md;
            for (int i = 1; i <= lat; i++) begin
                mem_ready = (i == lat);
                mem_rdata = (i == lat) ? md : 16'($urandom);
                tick(1'b0, 1'b0, 16'h0, 16'h0, rexp);
                if (i < lat) begin
                    check("mem_en_hold", mem_en, 1'b1);
                    check("mem_addr_hold", mem_addr, a);
                    check("bus_ready_wait", bus_if.ready, 1'b0);
                end
            end
            mem_ready = 1'b0;
            check("mem_en_end", mem_en, 1'b0);
        end else begin
            tick(1'b1, we, a, wd, rexp);
            exp_rd = we ? 16'h0000 : rexp;
        end
        check("bus_ready", bus_if.ready, 1'b1);
        check("bus_rdata", bus_if.rdata, exp_rd);
        got       = bus_if.rdata;
        bus_if.rd = 1'b0;
        bus_if.we = 1'b0;
        tick(1'b0, 1'b0, 16'h0, 16'h0, rexp);
        check("bus_ready_pulse", bus_if.ready, 1'b0);
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] r;
        logic [15:0] a;
        bit          we;
        n_checks     = 0;
        n_errors     = 0;
        rand_io      = 1'b0;
        mem_rdata    = 16'h0;
        kbd_data     = 8'h00;
        bus_if.addr  = 16'h0;
        bus_if.wdata = 16'h0;

        do_reset();
        check("rst_run", run, 1'b1);
        check("rst_kbd_ready", kbd_ready, 1'b1);
        check("rst_disp_valid", disp_valid, 1'b0);
        check("rst_disp_data", disp_data, 8'h00);
        check("rst_bus_ready", bus_if.ready, 1'b0);
        check("rst_bus_rdata", bus_if.rdata, 16'h0);
        check("rst_mem_en", mem_en, 1'b0);
        idle(2);
        do_access(1'b0, 16'hFFFE, 16'h0, 0, 16'h0, got);
        check("mcr_reset", got, 16'h8000);

        do_access(1'b0, 16'h3000, 16'h0, 3, 16'h1234, got);
        check("mem_read", got, 16'h1234);

        // Fill the FIFO, then try one more
        for (int i = 0; i < 5; i++) begin
            kbd_valid = 1'b1;
            kbd_data  = 8'h41 + 8'(i);
            tick(1'b0, 1'b0, 16'h0, 16'h0, r);
        end
        kbd_valid = 1'b0;
        check("kbd_full", kbd_ready, 1'b0);
        do_access(1'b0, 16'hFE00, 16'h0, 0, 16'h0, got);
        check("kbsr_full", got, 16'h8000);
        for (int i = 0; i < 4; i++) begin
            do_access(1'b0, 16'hFE02, 16'h0, 0, 16'h0, got);
            check("kbdr_pop", got, 16'h0041 + 16'(i));
        end
        do_access(1'b0, 16'hFE00, 16'h0, 0, 16'h0, got);
        check("kbsr_empty", got, 16'h0000);
        do_access(1'b0, 16'hFE02, 16'h0, 0, 16'h0, got);
        check("kbdr_empty", got, 16'h0000);

        // Display: second write while busy is dropped
        disp_ready = 1'b0;
        do_access(1'b1, 16'hFE06, 16'h0048, 0, 16'h0, got);
        check("ddr_valid", disp_valid, 1'b1);
        check("ddr_data", disp_data, 8'h48);
        do_access(1'b0, 16'hFE04, 16'h0, 0, 16'h0, got);
        check("dsr_busy", got, 16'h0000);
        do_access(1'b1, 16'hFE06, 16'h0049, 0, 16'h0, got);
        check("ddr_dropped", disp_data, 8'h48);
        disp_ready = 1'b1;
        tick(1'b0, 1'b0, 16'h0, 16'h0, r);
        disp_ready = 1'b0;
        check("disp_consumed", disp_valid, 1'b0);
        do_access(1'b0, 16'hFE04, 16'h0, 0, 16'h0, got);
        check("dsr_free", got, 16'h8000);
        check("disp_data_kept", disp_data, 8'h48);

        // MCR clear stops run but not the bus or FIFO
        do_access(1'b1, 16'hFFFE, 16'h0000, 0, 16'h0, got);
        check("run_cleared", run, 1'b0);
        kbd_valid = 1'b1;
        kbd_data  = 8'h5A;
        tick(1'b0, 1'b0, 16'h0, 16'h0, r);
        kbd_valid = 1'b0;
        do_access(1'b0, 16'hFE00, 16'h0, 0, 16'h0, got);
        check("kbsr_while_halted", got, 16'h8000);
        do_access(1'b0, 16'hFE02, 16'h0, 0, 16'h0, got);
        check("kbdr_while_halted", got, 16'h005A);

        // Reset in the middle of a memory access
        bus_if.addr = 16'h4000;
        bus_if.rd   = 1'b1;
        tick(1'b0, 1'b0, 16'h0, 16'h0, r);
        check("mem_en_before_rst", mem_en, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_mem_en", mem_en, 1'b0);
        check("rst_mid_ready", bus_if.ready, 1'b0);
        bus_if.rd = 1'b0;
        rst_n     = 1'b1;
        m_kq.delete();
        m_dv  = 1'b0;
        m_dd  = 8'h00;
        m_mcr = 16'h8000;
        do_access(1'b0, 16'h4001, 16'h0, 0, 16'hBEEF, got);
        check("mem_after_rst", got, 16'hBEEF);

        // Randomized traffic
        rand_io = 1'b1;
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 7))
                0, 1:    a = 16'($urandom_range(0, 16'hFDFF));
                2:       a = 16'hFE00;
                3:       a = 16'hFE02;
                4:       a = 16'hFE04;
                5:       a = 16'hFE06;
                6:       a = 16'hFFFE;
                default: a = 16'hFE00 | 16'($urandom_range(0, 16'h1FF));
            endcase
            we = 1'($urandom);
            do_access(we, a, 16'($urandom), 0, 16'($urandom), got);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
